// File: rtl/seg_scan_display.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous double buffering.
// Define SEG_LZB_EN to enable leading-zero blanking of the upper digits.

module seg_scan_lane (
  input  logic [3:0] val,
  input  logic       dp,
  input  logic       en,
  input  logic       lzBlank,
  output logic [0:7] lit
);
  // Active-high lit pattern, index 0..6 = a..g (literals read left to right as abcdefg)
  logic [0:6] hex;

  always_comb begin
    hex = '0;
    case (val)
      4'h0: hex = 7'b1111110;
      4'h1: hex = 7'b0110000;
      4'h2: hex = 7'b1101101;
      4'h3: hex = 7'b1111001;
      4'h4: hex = 7'b0110011;
      4'h5: hex = 7'b1011011;
      4'h6: hex = 7'b1011111;
      4'h7: hex = 7'b1110000;
      4'h8: hex = 7'b1111111;
      4'h9: hex = 7'b1111011;
      4'hA: hex = 7'b1110111;
      4'hB: hex = 7'b0011111;
      4'hC: hex = 7'b1001110;
      4'hD: hex = 7'b0111101;
      4'hE: hex = 7'b1001111;
      4'hF: hex = 7'b1000111;
      default: hex = '0;
    endcase
  end

  always_comb begin
    lit = '0;
    if (en) lit = {(lzBlank ? 7'b0 : hex), dp};
  end
endmodule

module seg_scan_display #(
  parameter int DIGITS         = 2,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clkI,
  input  logic                  rstI,
  input  logic [4*DIGITS-1:0]   valI,
  input  logic [DIGITS-1:0]     dpI,
  input  logic [DIGITS-1:0]     enI,
  input  logic                  loadI,
  output logic [0:7]            segO,
  output logic [DIGITS-1:0]     digO,
  output logic                  frameO
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] val;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      en;
  } dispBuf_t;

  dispBuf_t inBuf, pend, act;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          frameEdge;
  logic [0:0]    phase;
  logic [DIGITS-1:0]      lzb;
  logic [DIGITS-1:0][0:7] laneLit;
  logic [0:7]             selSeg;
  logic [DIGITS-1:0]      selDig;

  assign inBuf.val = valI;
  assign inBuf.dp  = dpI;
  assign inBuf.en  = enI;
  assign frameEdge = (cnt == CNT_MAX) && (idx == IDX_MAX);
  assign phase     = (cnt < BLANK_LIM) ? BLANK : SHOW;

  // Active buffer only moves on the wrap edge, so a frame never tears
  always_ff @(posedge clkI) begin
    if (rstI) begin
      cnt  <= '0;
      idx  <= '0;
      pend <= '0;
      act  <= '0;
    end else begin
      if (loadI) pend <= inBuf;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        if (frameEdge) begin
          idx <= '0;
          act <= loadI ? inBuf : pend;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SEG_LZB_EN
  always_comb begin
    logic run;
    lzb = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run    = run & (act.val[k] == 4'd0);
      lzb[k] = run;
    end
  end
`else
  assign lzb = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    seg_scan_lane u_lane (
      .val     (act.val[k]),
      .dp      (act.dp[k]),
      .en      (act.en[k]),
      .lzBlank (lzb[k]),
      .lit     (laneLit[k])
    );
  end

  always_comb begin
    selSeg = '0;
    selDig = '0;
    if (phase == SHOW) begin
      selSeg      = laneLit[idx];
      selDig[idx] = act.en[idx];
    end
  end

  // Polarity is folded in only here; everything upstream is active-high
  always_ff @(posedge clkI) begin
    if (rstI) begin
      segO   <= {8{SEG_ACTIVE_LOW}};
      digO   <= {DIGITS{DIG_ACTIVE_LOW}};
      frameO <= 1'b0;
    end else begin
      segO   <= selSeg ^ {8{SEG_ACTIVE_LOW}};
      digO   <= selDig ^ {DIGITS{DIG_ACTIVE_LOW}};
      frameO <= frameEdge;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench: a frame-position model pushes expected outputs each cycle, a monitor pops and compares.
module tb_seg_scan_display;
  localparam int DIGITS    = 2;
  localparam int CLK_HZ    = 1000;
  localparam int SCAN_HZ   = 100;
  localparam int BLANK_CYC = 2;
  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int FRAME     = DIGITS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [4*DIGITS-1:0] val = '0;
  logic [DIGITS-1:0]   dp = '0;
  logic [DIGITS-1:0]   en = '0;
  logic [0:7]          segO;
  logic [DIGITS-1:0]   digO;
  logic                frameO;

  typedef struct {
    logic [0:7]        seg;
    logic [DIGITS-1:0] dig;
    logic              frame;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int mpos = 0;
  logic [3:0] actVal [DIGITS];
  logic [3:0] pendVal [DIGITS];
  logic       actDp [DIGITS];
  logic       pendDp [DIGITS];
  logic       actEn [DIGITS];
  logic       pendEn [DIGITS];
  string hexSegs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg_scan_display #(
    .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYC(BLANK_CYC),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clkI(clk), .rstI(rst), .valI(val), .dpI(dp), .enI(en), .loadI(load),
    .segO(segO), .digO(digO), .frameO(frameO)
  );

  always #5 clk = ~clk;

  function automatic logic [0:6] litOf(input logic [3:0] v);
    logic [0:6] r;
    string s;
    r = '0;
    s = hexSegs[v];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  // Reference: position within the frame picks digit and dwell offset
  always @(posedge clk) begin : model
    exp_t e;
    int d, off;
    logic [0:6] lit;
    logic lead;
    e.seg = '1;
    e.dig = '1;
    e.frame = 1'b0;
    if (rst) begin
      mpos = 0;
      for (int k = 0; k < DIGITS; k++) begin
        actVal[k] = 0; pendVal[k] = 0; actDp[k] = 0; pendDp[k] = 0; actEn[k] = 0; pendEn[k] = 0;
      end
    end else begin
      d = mpos / DIV;
      off = mpos % DIV;
      e.frame = (mpos == FRAME - 1);
      if (off >= BLANK_CYC && actEn[d]) begin
        lit = litOf(actVal[d]);
`ifdef SEG_LZB_EN
        if (d != 0) begin
          lead = 1'b1;
          for (int j = d; j < DIGITS; j++) if (actVal[j] != 0) lead = 1'b0;
          if (lead) lit = '0;
        end
`endif
        for (int k = 0; k < 7; k++) e.seg[k] = ~lit[k];
        e.seg[7] = ~actDp[d];
        e.dig[d] = 1'b0;
      end
      if (load) begin
        for (int k = 0; k < DIGITS; k++) begin
          pendVal[k] = val[4*k +: 4]; pendDp[k] = dp[k]; pendEn[k] = en[k];
        end
      end
      if (mpos == FRAME - 1) begin
        for (int k = 0; k < DIGITS; k++) begin
          actVal[k] = pendVal[k]; actDp[k] = pendDp[k]; actEn[k] = pendEn[k];
        end
      end
      mpos = (mpos + 1) % FRAME;
    end
    q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
    end else begin
      e = q.pop_front();
      chk("segO", 32'(segO), 32'(e.seg));
      chk("digO", 32'(digO), 32'(e.dig));
      chk("frameO", 32'(frameO), 32'(e.frame));
      chk("digOneHot", 32'($countones(~digO) <= 1), 32'd1);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doLoad(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] p,
                        input logic [DIGITS-1:0] e);
    val = v; dp = p; en = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge before the posedge where the model sits at position p
  task automatic waitPos(input int p);
    int n = 0;
    while (mpos != p && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [4*DIGITS-1:0] v;
    run(3);
    rst = 1'b0;
    run(45);
    doLoad(8'h3A, 2'b01, 2'b11);
    run(50);
    waitPos(4);
    doLoad(8'h11, 2'b00, 2'b11);
    waitPos(12);
    doLoad(8'h22, 2'b00, 2'b11);
    run(30);
    waitPos(FRAME - 1);
    doLoad(8'h47, 2'b10, 2'b11);
    run(30);
    doLoad(8'h3A, 2'b10, 2'b01);
    run(45);
    waitPos(5);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(25);
    doLoad(8'h05, 2'b00, 2'b11);
    run(45);
    doLoad(8'h00, 2'b11, 2'b11);
    run(45);
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < DIGITS; k++)
        v[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      doLoad(v, DIGITS'($urandom), DIGITS'($urandom));
      run($urandom_range(1, 30));
    end
    run(45);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
